// File: rtl/flappy_bird_control_sysid_checker_if.sv
// Avalon-MM read-only bus between the image checker and the sysid control slave.
interface flappy_bird_control_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (output avm_address, avm_read, input avm_readdata, avm_waitrequest);
    modport slave  (input avm_address, avm_read, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/flappy_bird_control_sysid_checker.sv
// Reads sysid ID and timestamp words over Avalon-MM, compares them to build-time
// values and reports pass/fail so game start can be gated on a verified image.
module flappy_bird_control_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480645824,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    flappy_bird_control_sysid_checker_if.master avm,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  error_code,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);
    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_RD_TS, S_GAP, S_CHECK} state_t;

    state_t           state;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_cnt_inc;
    logic [3:0]       retries;
    logic [1:0]       final_code;

    assign to_cnt_inc = to_cnt + 1'b1;

    // Result is decided on the edge that captures the timestamp, so the check
    // uses the live readdata rather than the not-yet-updated register.
    always_comb begin
        final_code = 2'd0;
        if (id_value != EXPECTED_ID)
            final_code = 2'd1;
        else if (avm.avm_readdata != EXPECTED_TIMESTAMP)
            final_code = 2'd2;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            to_cnt          <= '0;
            retries         <= '0;
            avm.avm_read    <= 1'b0;
            avm.avm_address <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            error_code      <= 2'd0;
            id_value        <= '0;
            timestamp_value <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state           <= S_RD_ID;
                        avm.avm_read    <= 1'b1;
                        avm.avm_address <= 1'b0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        error_code      <= 2'd0;
                        retries         <= '0;
                        to_cnt          <= '0;
                    end
                end
                S_RD_ID, S_RD_TS: begin
                    if (!avm.avm_waitrequest) begin
                        to_cnt <= '0;
                        if (state == S_RD_ID) begin
                            id_value        <= avm.avm_readdata;
                            avm.avm_address <= 1'b1;
                            state           <= S_RD_TS;
                        end else begin
                            timestamp_value <= avm.avm_readdata;
                            avm.avm_read    <= 1'b0;
                            error_code      <= final_code;
                            pass            <= (final_code == 2'd0);
                            done            <= 1'b1;
                            state           <= S_CHECK;
                        end
                    end else if (to_cnt_inc == TO_LAST) begin
                        to_cnt       <= '0;
                        avm.avm_read <= 1'b0;
                        if (retries < RETRY_MAX) begin
                            retries <= retries + 4'd1;
                            state   <= S_GAP;
                        end else begin
                            error_code <= 2'd3;
                            pass       <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_CHECK;
                        end
                    end else begin
                        to_cnt <= to_cnt_inc;
                    end
                end
                // Address is left untouched across the gap, so it selects the read to reissue.
                S_GAP: begin
                    avm.avm_read <= 1'b1;
                    state        <= avm.avm_address ? S_RD_TS : S_RD_ID;
                end
                S_CHECK: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flappy_bird_control_sysid_checker.sv
// Directed bench for the sysid image checker: zero-wait, stalls, timeouts, reset abort.
module tb_flappy_bird_control_sysid_checker;
    localparam logic [31:0] EXP_TS = 32'd1480645824;

    logic clock = 1'b0;
    logic reset, start, start2;
    always #5 clock = ~clock;

    flappy_bird_control_sysid_checker_if bus ();
    flappy_bird_control_sysid_checker_if bus2 ();

    logic        busy, done, pass, busy2, done2, pass2;
    logic [1:0]  ec, ec2;
    logic [31:0] idv, tsv, idv2, tsv2;

    logic [31:0] id_resp, ts_resp;
    int          stall_len, sc;
    int          n_cmp = 0, n_bad = 0;

    assign bus.avm_readdata    = bus.avm_address ? ts_resp : id_resp;
    assign bus.avm_waitrequest = bus.avm_read && (sc < stall_len);
    assign bus2.avm_readdata    = 32'd0;
    assign bus2.avm_waitrequest = 1'b1;

    always @(posedge clock or posedge reset)
        if (reset) sc <= 0;
        else if (bus.avm_read && bus.avm_waitrequest) sc <= sc + 1;
        else sc <= 0;

    flappy_bird_control_sysid_checker dut (
        .clock(clock), .reset(reset), .start(start), .avm(bus),
        .busy(busy), .done(done), .pass(pass), .error_code(ec),
        .id_value(idv), .timestamp_value(tsv));

    flappy_bird_control_sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(1)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .avm(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .error_code(ec2),
        .id_value(idv2), .timestamp_value(tsv2));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        id_resp = 32'd0; ts_resp = EXP_TS; stall_len = 0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if ({bus.avm_read, bus.avm_address} !== 2'b00) begin n_bad++; $display("FAIL reset_bus got %b want 00", {bus.avm_read, bus.avm_address}); end
        n_cmp++; if ({busy, done, pass, ec} !== 5'd0) begin n_bad++; $display("FAIL reset_status got %b want 00000", {busy, done, pass, ec}); end
        n_cmp++; if (idv !== 32'd0 || tsv !== 32'd0) begin n_bad++; $display("FAIL reset_values got %h/%h want 0/0", idv, tsv); end
        n_cmp++; if ({bus2.avm_read, busy2} !== 2'b00) begin n_bad++; $display("FAIL reset_dut2 got %b want 00", {bus2.avm_read, busy2}); end
    endtask

    task automatic test_pass;
        id_resp = 32'd0; ts_resp = EXP_TS; stall_len = 0;
        run_start();
        n_cmp++; if ({bus.avm_read, bus.avm_address, busy} !== 3'b101) begin n_bad++; $display("FAIL pass_n1 got %b want 101", {bus.avm_read, bus.avm_address, busy}); end
        tick();
        n_cmp++; if ({bus.avm_read, bus.avm_address, done} !== 3'b110) begin n_bad++; $display("FAIL pass_n2 got %b want 110", {bus.avm_read, bus.avm_address, done}); end
        tick();
        n_cmp++; if ({done, pass, ec, busy, bus.avm_read} !== 6'b110010) begin n_bad++; $display("FAIL pass_n3 got %b want 110010", {done, pass, ec, busy, bus.avm_read}); end
        n_cmp++; if (tsv !== EXP_TS) begin n_bad++; $display("FAIL pass_ts got %0d want %0d", tsv, EXP_TS); end
        tick();
        n_cmp++; if ({busy, done, pass} !== 3'b001) begin n_bad++; $display("FAIL pass_n4 got %b want 001", {busy, done, pass}); end
    endtask

    task automatic test_mismatch;
        id_resp = 32'd5; ts_resp = EXP_TS;
        run_start(); tick(); tick();
        n_cmp++; if ({done, pass, ec} !== 4'b1001) begin n_bad++; $display("FAIL id_mis got %b want 1001", {done, pass, ec}); end
        n_cmp++; if (idv !== 32'd5) begin n_bad++; $display("FAIL id_mis_val got %h want 5", idv); end
        tick();
        ts_resp = 32'h1234_5678;
        run_start(); tick(); tick();
        n_cmp++; if ({done, pass, ec} !== 4'b1001) begin n_bad++; $display("FAIL both_mis got %b want 1001", {done, pass, ec}); end
        tick();
        id_resp = 32'd0;
        run_start(); tick(); tick();
        n_cmp++; if ({done, pass, ec} !== 4'b1010) begin n_bad++; $display("FAIL ts_mis got %b want 1010", {done, pass, ec}); end
        n_cmp++; if (tsv !== 32'h1234_5678) begin n_bad++; $display("FAIL ts_mis_val got %h want 12345678", tsv); end
        tick();
        ts_resp = EXP_TS;
    endtask

    task automatic test_wait;
        stall_len = 3;
        run_start();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({bus.avm_read, bus.avm_address} !== 2'b10) begin n_bad++; $display("FAIL wait_id_c%0d got %b want 10", i, {bus.avm_read, bus.avm_address}); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({bus.avm_read, bus.avm_address, done} !== 3'b110) begin n_bad++; $display("FAIL wait_ts_c%0d got %b want 110", i, {bus.avm_read, bus.avm_address, done}); end
            tick();
        end
        n_cmp++; if ({done, pass, ec} !== 4'b1100) begin n_bad++; $display("FAIL wait_done got %b want 1100", {done, pass, ec}); end
        tick();
        stall_len = 0;
    endtask

    task automatic test_timeout;
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus2.avm_read !== 1'b1) begin n_bad++; $display("FAIL to_read1_c%0d got %b want 1", i, bus2.avm_read); end
            tick();
        end
        n_cmp++; if ({bus2.avm_read, busy2} !== 2'b01) begin n_bad++; $display("FAIL to_gap got %b want 01", {bus2.avm_read, busy2}); end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({bus2.avm_read, bus2.avm_address, done2} !== 3'b100) begin n_bad++; $display("FAIL to_read2_c%0d got %b want 100", i, {bus2.avm_read, bus2.avm_address, done2}); end
            tick();
        end
        n_cmp++; if ({done2, pass2, ec2, bus2.avm_read} !== 5'b10110) begin n_bad++; $display("FAIL to_done got %b want 10110", {done2, pass2, ec2, bus2.avm_read}); end
        tick();
        n_cmp++; if ({busy2, done2} !== 2'b00) begin n_bad++; $display("FAIL to_idle got %b want 00", {busy2, done2}); end
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        run_start(); tick();
        start = 1'b1;           // during RD_TS
        tick();
        if (done) dones++;      // CHECK cycle, start still high
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
        for (int i = 0; i < 5; i++) begin
            if (done) dones++;
            tick();
        end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL b2b_dones got %0d want 1", dones); end
        run_start(); tick(); tick();
        n_cmp++; if ({done, pass, ec} !== 4'b1100) begin n_bad++; $display("FAIL b2b_fresh got %b want 1100", {done, pass, ec}); end
        tick();
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        stall_len = 100;
        run_start(); tick();
        n_cmp++; if ({bus.avm_read, bus.avm_address} !== 2'b10) begin n_bad++; $display("FAIL rst_pre got %b want 10", {bus.avm_read, bus.avm_address}); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.avm_read !== 1'b0) begin n_bad++; $display("FAIL rst_async_read got %b want 0", bus.avm_read); end
        n_cmp++; if ({busy, done, pass, ec} !== 5'd0) begin n_bad++; $display("FAIL rst_status got %b want 00000", {busy, done, pass, ec}); end
        n_cmp++; if (idv !== 32'd0 || tsv !== 32'd0) begin n_bad++; $display("FAIL rst_values got %h/%h want 0/0", idv, tsv); end
        tick();
        reset = 1'b0; stall_len = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            tick();
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rst_no_done got %0d want 0", dones); end
        run_start(); tick(); tick();
        n_cmp++; if ({done, pass, ec} !== 4'b1100) begin n_bad++; $display("FAIL rst_recover got %b want 1100", {done, pass, ec}); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
